// File: rtl/fp_to_fixed.sv
// Two-stage valid/ready converter from the compact float format to signed
// two's-complement fixed point with saturation and an overflow flag.
module fp_to_fixed #(
  parameter int EXP    = 8,
  parameter int MANT   = 23,
  parameter int WIDTH  = EXP + MANT + 1,
  parameter int OWIDTH = 32,
  parameter int FRAC   = 16
) (
  input  logic              clock,
  input  logic              clock_sreset,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [WIDTH-1:0]  data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [OWIDTH-1:0] result,
  output logic              overflow
);

  // Shift width covers the whole exponent range plus the FRAC/MANT offset.
  localparam int SHW  = EXP + 2 + $clog2(FRAC + MANT + 2);
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  localparam logic signed [SHW-1:0] SH_OFF  = SHW'(FRAC - MANT - BIAS);
  localparam logic signed [SHW-1:0] OVF_SH  = SHW'(OWIDTH - 1 - MANT);
  localparam logic        [SHW-1:0] MANT_SH = SHW'(MANT);
  localparam logic [OWIDTH-1:0] POS_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0] NEG_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s1_sign_q, s1_zero_q;
  logic [MANT:0]         s1_mag_q;
  logic signed [SHW-1:0] s1_sh_q, sh_s;
  logic [OWIDTH-1:0]     result_q, result_d;
  logic                  overflow_q, overflow_d;
  logic                  s1_load_s, s2_load_s;
  logic [SHW-1:0]        nsh_s;
  logic [OWIDTH-1:0]     mag_s, s2_res_s;
  logic                  s2_ovf_s, min_exact_s;

  assign s2_load_s    = ~s2_valid_q | result_ready;
  assign s1_load_s    = ~s1_valid_q | s2_load_s;
  assign data_ready   = s1_load_s;
  assign result_valid = s2_valid_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign sh_s = $signed({{(SHW-EXP){1'b0}}, data[WIDTH-2:MANT]}) + SH_OFF;

  // Stage-1 operand capture; these registers are don't-care while s1 is empty.
  always_ff @(posedge clock) begin
    if (data_valid && s1_load_s) begin
      s1_sign_q <= data[WIDTH-1];
      s1_zero_q <= (data[WIDTH-2:0] == '0);
      s1_mag_q  <= {1'b1, data[MANT-1:0]};
      s1_sh_q   <= sh_s;
    end
  end

  // Stage-2 conversion: alignment shift, saturation and sign application.
  always_comb begin
    mag_s       = '0;
    s2_res_s    = '0;
    s2_ovf_s    = 1'b0;
    nsh_s       = $unsigned(-s1_sh_q);
    min_exact_s = s1_sign_q && (s1_mag_q[MANT-1:0] == '0) && (s1_sh_q == OVF_SH);
    if (s1_zero_q) begin
      s2_res_s = '0;
    end else if (s1_sh_q[SHW-1]) begin
      if (nsh_s > MANT_SH) begin
        mag_s = '0;
      end else begin
        mag_s = OWIDTH'(s1_mag_q) >> nsh_s;
      end
      s2_res_s = s1_sign_q ? -mag_s : mag_s;
    end else if ((s1_sh_q >= OVF_SH) && !min_exact_s) begin
      s2_ovf_s = 1'b1;
      s2_res_s = s1_sign_q ? NEG_MIN : POS_MAX;
    end else begin
      mag_s    = OWIDTH'(s1_mag_q) << $unsigned(s1_sh_q);
      s2_res_s = s1_sign_q ? -mag_s : mag_s;
    end
  end

  // Pipeline flow control and output hold under backpressure.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    if (s1_load_s) begin
      s1_valid_d = data_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = s2_res_s;
        overflow_d = s2_ovf_s;
      end else begin
        result_d   = result_q;
        overflow_d = overflow_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage valid flags and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge clock_sreset) begin
    if (!clock_sreset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/fp_to_fixed.md
Name: fp_to_fixed

Overview:
- Pipelined converter from the team's compact float format to signed two's-complement fixed point.
- Float format: [s][EXP exponent, bias 2^(EXP-1)-1][MANT mantissa], implied leading 1, zero when all non-sign bits are 0, no NaN/Inf/denormal handling.
- Sits at the back end of the fp_add / accumulator datapath and hands results to integer post-processing (activation quantisation, output DMA).
- Valid/ready streaming on both sides, two register stages.

Parameters:
EXP, 8, exponent width
MANT, 23, mantissa width (explicit bits)
WIDTH, EXP+MANT+1, input float width
OWIDTH, 32, output fixed-point width including sign bit
FRAC, 16, fractional bits in output

Ports:
clock  input  1  system clock, rising edge
clock_sreset  input  1  reset, asynchronous, active-low (0 = reset asserted)
data_valid  input  1  input word valid
data_ready  output  1  converter can accept input this cycle
data  input  WIDTH  float operand
result_valid  output  1  result word valid
result_ready  input  1  downstream accepts result this cycle
result  output  OWIDTH  signed fixed-point result
overflow  output  1  result was saturated; qualified by result_valid

Behaviour:
- Reset: while clock_sreset is 0, both stage-valid flags clear immediately (async). result_valid=0, result=0, overflow=0. data_ready=1 once reset is released. Data registers need no reset; result and overflow are reset.
- Input transfer: data_valid & data_ready at a rising edge. Output transfer: result_valid & result_ready.
- Stage 1 (S1) registers:
  - sign;
  - zero flag (data[WIDTH-2:0]==0);
  - magnitude m = {1,data[MANT-1:0]}, MANT+1 bits;
  - signed shift sh = e - bias + FRAC - MANT. Use enough bits that the full exponent range does not wrap: EXP+2 bits, or more if FRAC/MANT require it.
- Stage 2 (S2) computes and registers result/overflow:
  - zero: 0, overflow=0.
  - sh < 0: mag = m >> (-sh); mag=0 if -sh > MANT. This truncates toward zero on magnitude.
  - sh >= 0: check MANT+sh >= OWIDTH-1. If true, this is overflow, except when sign=1, mantissa bits are all 0 and MANT+sh == OWIDTH-1; that case is exactly -2^(OWIDTH-1) and is not overflow.
  - On overflow: result = 2^(OWIDTH-1)-1 if positive, -2^(OWIDTH-1) if negative, and overflow=1.
  - Otherwise mag = m << sh.
  - Non-overflow output: result = sign ? -mag : mag. Negative rounding is therefore toward zero.
- Pipeline flow:
  - S2 loads when S2 is empty or result_ready=1.
  - S1 loads when S1 is empty or S2 loads.
  - data_ready = ~s1_valid | s2_load. This is a combinational path from result_ready, which is accepted.
- Latency: 2 cycles from input transfer to result_valid when there is no backpressure. Throughput is 1 word per cycle.
- Backpressure: while result_valid=1 and result_ready=0, result and overflow hold stable and no data is lost. With S1 and S2 both full, data_ready=0.
- Simultaneous accept and emit in one cycle is legal and sustains full throughput.
- Reset mid-stream discards all in-flight words. No partial result is emitted after reset release.
- Order preserved; no reordering or duplication.

Test Plan:
All values use defaults (EXP=8, MANT=23, OWIDTH=32, FRAC=16).
1. Reset, then send 0x3F800000 (1.0) with result_ready=1 -> result_valid after 2 cycles, result=0x00010000, overflow=0.
2. Send 0xC0200000 (-2.5) -> result 0xFFFD8000. Send 0x3F800001 -> result 0x00010000 (truncated).
3. Send 0x47800000 (65536.0) -> result 0x7FFFFFFF, overflow=1. Send 0xC7000000 (-32768.0) -> result 0x80000000, overflow=0. Send 0xC7800000 -> result 0x80000000, overflow=1.
4. Send 0x35800000 (2^-20), 0x00000000 and 0x80000000 -> all give result 0, overflow=0.
5. Stream 10 back-to-back words while holding result_ready=0 for cycles 3-6. Required response:
   - data_ready=0 once both stages are full;
   - result holds stable during the stall;
   - all 10 results arrive in order with no gaps once ready returns.
6. Drive clock_sreset=0 asynchronously, between clock edges, with 2 words in flight -> result_valid=0 immediately. After release, no stale result appears and data_ready=1.
